// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the decode pipeline: opcodes, instruction field
// positions, the ID/EX bundle and small decode helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_ADD    = 4'h1,
        OP_SUB    = 4'h2,
        OP_AND    = 4'h3,
        OP_OR     = 4'h4,
        OP_XOR    = 4'h5,
        OP_SHL    = 4'h6,
        OP_SHR    = 4'h7,
        OP_LD     = 4'h8,
        OP_ST     = 4'h9,
        OP_LDI    = 4'hA,
        OP_BR     = 4'hB,
        OP_JMP    = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_RSVD_E = 4'hE,
        OP_HALT   = 4'hF
    } opcode_e;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS_MSB = 7;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 0;
    localparam int IMM_W  = 16;

    typedef struct packed {
        logic             valid;
        logic [3:0]       op;
        logic [3:0]       rd;
        logic [3:0]       rs;
        logic [3:0]       rt;
        logic [IMM_W-1:0] imm;
    } dx_t;

    function automatic logic reads_rs(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_ST)) || (op == OP_BR);
    endfunction

    function automatic logic reads_rt(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_ST);
    endfunction

    // Reserved opcodes still issue, but as an all-zero NOP.
    function automatic logic is_defined(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    function automatic logic signed [IMM_W-1:0] sext8(input logic [7:0] v);
        return {{(IMM_W-8){v[7]}}, v};
    endfunction

    function automatic logic signed [IMM_W-1:0] sext12(input logic [11:0] v);
        return {{(IMM_W-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use detection and per-cycle priority resolution for the decode stage;
// turns flush/hold/halt/hazard/jump conditions into register controls.
module hazard_unit
    import cpu_pkg::*;
(
    input  logic       i_ex_flush,
    input  logic       i_ex_stall,
    input  logic       i_halted,
    input  logic       i_dx_valid,
    input  logic [3:0] i_dx_op,
    input  logic [3:0] i_dx_rd,
    input  logic       i_id_valid,
    input  logic [3:0] i_id_op,
    input  logic [3:0] i_id_rs,
    input  logic [3:0] i_id_rt,
    output logic       o_stall,
    output logic       o_branch_to_new,
    output logic       o_ifid_hold,
    output logic       o_ifid_squash,
    output logic       o_dx_hold,
    output logic       o_dx_bubble
);

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_ld_use;
    logic w_jmp;

    assign w_rs_hit = reads_rs(i_id_op) && (i_id_rs == i_dx_rd);
    assign w_rt_hit = reads_rt(i_id_op) && (i_id_rt == i_dx_rd);
    assign w_ld_use = i_dx_valid && (i_dx_op == OP_LD) && i_id_valid && (w_rs_hit || w_rt_hit);
    assign w_jmp    = i_id_valid && (i_id_op == OP_JMP);

    always_comb begin
        o_stall         = 1'b0;
        o_branch_to_new = 1'b0;
        o_ifid_hold     = 1'b0;
        o_ifid_squash   = 1'b0;
        o_dx_hold       = 1'b0;
        o_dx_bubble     = 1'b0;
        if (i_ex_flush) begin
            o_ifid_squash = 1'b1;
            o_dx_bubble   = 1'b1;
        end else if (i_ex_stall) begin
            o_stall     = 1'b1;
            o_ifid_hold = 1'b1;
            o_dx_hold   = 1'b1;
        end else if (i_halted || w_ld_use) begin
            o_stall     = 1'b1;
            o_ifid_hold = 1'b1;
            o_dx_bubble = 1'b1;
        end else if (w_jmp) begin
            // Wrong-path slot arriving this edge is captured but invalidated.
            o_branch_to_new = 1'b1;
            o_ifid_squash   = 1'b1;
            o_dx_bubble     = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Second pipeline stage: IF/ID register, 16-bit instruction decode into the
// ID/EX register, decode-time jump redirect and halt latch.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int PC_W   = 16,
    parameter int INST_W = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst,
    input  logic              inst_invalid,
    input  logic              ex_stall,
    input  logic              ex_flush,
    output logic              stall,
    output logic              branch_to_new,
    output logic [PC_W-1:0]   branch_pc,
    output logic              dx_valid,
    output logic [PC_W-1:0]   dx_pc,
    output logic [3:0]        dx_op,
    output logic [3:0]        dx_rd,
    output logic [3:0]        dx_rs,
    output logic [3:0]        dx_rt,
    output logic [15:0]       dx_imm,
    output logic              halted
);

    logic [PC_W-1:0]   r_pc_p1;
    logic [INST_W-1:0] r_inst_p1;
    logic              r_vld_p1;
    dx_t               r_dx_p2;
    logic [PC_W-1:0]   r_dx_pc_p2;
    logic              r_halted;

    logic [3:0]        w_op;
    logic [3:0]        w_rd;
    logic [3:0]        w_rs;
    logic [3:0]        w_rt;
    dx_t               w_dx_dec;
    logic [PC_W-1:0]   w_jmp_off;
    logic              w_stall;
    logic              w_branch_to_new;
    logic              w_ifid_hold;
    logic              w_ifid_squash;
    logic              w_dx_hold;
    logic              w_dx_bubble;

    assign w_op = r_inst_p1[OP_MSB:OP_LSB];
    assign w_rd = r_inst_p1[RD_MSB:RD_LSB];
    assign w_rs = r_inst_p1[RS_MSB:RS_LSB];
    assign w_rt = r_inst_p1[RT_MSB:RT_LSB];

    hazard_unit u_hazard (
        .i_ex_flush      (ex_flush),
        .i_ex_stall      (ex_stall),
        .i_halted        (r_halted),
        .i_dx_valid      (r_dx_p2.valid),
        .i_dx_op         (r_dx_p2.op),
        .i_dx_rd         (r_dx_p2.rd),
        .i_id_valid      (r_vld_p1),
        .i_id_op         (w_op),
        .i_id_rs         (w_rs),
        .i_id_rt         (w_rt),
        .o_stall         (w_stall),
        .o_branch_to_new (w_branch_to_new),
        .o_ifid_hold     (w_ifid_hold),
        .o_ifid_squash   (w_ifid_squash),
        .o_dx_hold       (w_dx_hold),
        .o_dx_bubble     (w_dx_bubble)
    );

    always_comb begin
        w_dx_dec = '0;
        if (r_vld_p1) begin
            w_dx_dec.valid = 1'b1;
            if (is_defined(w_op)) begin
                w_dx_dec.op = w_op;
                w_dx_dec.rd = w_rd;
                w_dx_dec.rs = w_rs;
                w_dx_dec.rt = w_rt;
                if (w_op == OP_LDI) begin
                    w_dx_dec.imm = sext8(r_inst_p1[7:0]);
                end else if ((w_op == OP_BR) || (w_op == OP_JMP)) begin
                    w_dx_dec.imm = sext12(r_inst_p1[11:0]);
                end
            end
        end
    end

    // Target wraps mod 2^PC_W; driven whenever the IF/ID opcode is JMP.
    assign w_jmp_off = PC_W'(sext12(r_inst_p1[11:0]));
    assign branch_pc = (w_op == OP_JMP) ? (r_pc_p1 + w_jmp_off) : '0;

    assign stall         = w_stall & ~rst;
    assign branch_to_new = w_branch_to_new & ~rst;

    // IF/ID boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_p1   <= '0;
            r_inst_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else if (!w_ifid_hold) begin
            r_pc_p1   <= pc;
            r_inst_p1 <= inst;
            r_vld_p1  <= !inst_invalid && !w_ifid_squash;
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dx_p2    <= '0;
            r_dx_pc_p2 <= '0;
            r_halted   <= 1'b0;
        end else if (!w_dx_hold) begin
            if (w_dx_bubble) begin
                r_dx_p2    <= '0;
                r_dx_pc_p2 <= '0;
            end else begin
                r_dx_p2    <= w_dx_dec;
                r_dx_pc_p2 <= r_vld_p1 ? r_pc_p1 : '0;
                if (r_vld_p1 && (w_op == OP_HALT)) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    assign dx_valid = r_dx_p2.valid;
    assign dx_pc    = r_dx_pc_p2;
    assign dx_op    = r_dx_p2.op;
    assign dx_rd    = r_dx_p2.rd;
    assign dx_rs    = r_dx_p2.rs;
    assign dx_rt    = r_dx_p2.rt;
    assign dx_imm   = r_dx_p2.imm;
    assign halted   = r_halted;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized bench for decode_stage against a cycle-level
// reference model derived from the ISA and priority rules.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc = '0;
    logic [15:0] inst = '0;
    logic        inst_invalid = 1'b1;
    logic        ex_stall = 1'b0;
    logic        ex_flush = 1'b0;
    logic        stall;
    logic        branch_to_new;
    logic [15:0] branch_pc;
    logic        dx_valid;
    logic [15:0] dx_pc;
    logic [3:0]  dx_op;
    logic [3:0]  dx_rd;
    logic [3:0]  dx_rs;
    logic [3:0]  dx_rt;
    logic [15:0] dx_imm;
    logic        halted;

    decode_stage #(.PC_W(16), .INST_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .inst          (inst),
        .inst_invalid  (inst_invalid),
        .ex_stall      (ex_stall),
        .ex_flush      (ex_flush),
        .stall         (stall),
        .branch_to_new (branch_to_new),
        .branch_pc     (branch_pc),
        .dx_valid      (dx_valid),
        .dx_pc         (dx_pc),
        .dx_op         (dx_op),
        .dx_rd         (dx_rd),
        .dx_rs         (dx_rs),
        .dx_rt         (dx_rt),
        .dx_imm        (dx_imm),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state: fetched slot, issued slot, halt flag.
    int m_id_v, m_id_pc, m_id_inst;
    int m_dx_v, m_dx_pc, m_dx_op, m_dx_rd, m_dx_rs, m_dx_rt, m_dx_imm;
    int m_halt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    task automatic model_reset();
        m_id_v = 0; m_id_pc = 0; m_id_inst = 0;
        m_dx_v = 0; m_dx_pc = 0; m_dx_op = 0; m_dx_rd = 0; m_dx_rs = 0; m_dx_rt = 0; m_dx_imm = 0;
        m_halt = 0;
    endtask

    task automatic model_bubble();
        m_dx_v = 0; m_dx_pc = 0; m_dx_op = 0; m_dx_rd = 0; m_dx_rs = 0; m_dx_rt = 0; m_dx_imm = 0;
    endtask

    task automatic check_dx(input string where);
        check({where, ".dx_valid"}, dx_valid, m_dx_v);
        check({where, ".dx_pc"},    dx_pc,    m_dx_pc);
        check({where, ".dx_op"},    dx_op,    m_dx_op);
        check({where, ".dx_rd"},    dx_rd,    m_dx_rd);
        check({where, ".dx_rs"},    dx_rs,    m_dx_rs);
        check({where, ".dx_rt"},    dx_rt,    m_dx_rt);
        check({where, ".dx_imm"},   dx_imm,   m_dx_imm);
        check({where, ".halted"},   halted,   m_halt);
    endtask

    // Called #1 after a rising edge; drives one fetch slot, checks fetch-side
    // outputs before the next edge and the ID/EX register after it.
    task automatic step(input int p, input int i, input bit inv, input bit xs, input bit xf);
        int  op, rd, rs, rt, mode, e_bpc;
        bit  use_rs, use_rt, lduse;
        pc = p[15:0]; inst = i[15:0]; inst_invalid = inv; ex_stall = xs; ex_flush = xf;
        #2;
        op = (m_id_inst >> 12) & 15;
        rd = (m_id_inst >> 8) & 15;
        rs = (m_id_inst >> 4) & 15;
        rt = m_id_inst & 15;
        use_rs = (op >= 1 && op <= 9) || op == 11;
        use_rt = (op >= 1 && op <= 7) || op == 9;
        lduse  = m_dx_v != 0 && m_dx_op == 8 && m_id_v != 0 &&
                 ((use_rs && rs == m_dx_rd) || (use_rt && rt == m_dx_rd));
        if (xf)                           mode = 0;
        else if (xs)                      mode = 1;
        else if (m_halt != 0)             mode = 2;
        else if (lduse)                   mode = 3;
        else if (m_id_v != 0 && op == 12) mode = 4;
        else                              mode = 5;
        e_bpc = (op == 12) ? ((m_id_pc + sext(m_id_inst & 'hFFF, 12)) & 'hFFFF) : 0;
        check("stall", stall, (mode >= 1 && mode <= 3));
        check("branch_to_new", branch_to_new, (mode == 4));
        check("branch_pc", branch_pc, e_bpc);
        @(posedge clk);
        #1;
        case (mode)
            0, 4: begin
                model_bubble();
                m_id_v = 0; m_id_pc = p & 'hFFFF; m_id_inst = i & 'hFFFF;
            end
            1: ;
            2, 3: model_bubble();
            default: begin
                model_bubble();
                m_dx_v = m_id_v;
                if (m_id_v != 0) begin
                    m_dx_pc = m_id_pc;
                    if (op <= 12 || op == 15) begin
                        m_dx_op = op; m_dx_rd = rd; m_dx_rs = rs; m_dx_rt = rt;
                        if (op == 10)                m_dx_imm = sext(m_id_inst & 'hFF, 8) & 'hFFFF;
                        else if (op == 11 || op == 12) m_dx_imm = sext(m_id_inst & 'hFFF, 12) & 'hFFFF;
                    end
                    if (op == 15) m_halt = 1;
                end
                m_id_v = inv ? 0 : 1; m_id_pc = p & 'hFFFF; m_id_inst = i & 'hFFFF;
            end
        endcase
        check_dx("post");
    endtask

    initial begin
        int rop, rinst;
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst.dx_valid", dx_valid, 0);
        check("rst.stall", stall, 0);
        check("rst.branch_to_new", branch_to_new, 0);
        check("rst.branch_pc", branch_pc, 0);
        check("rst.halted", halted, 0);
        check("rst.dx_op", dx_op, 0);
        rst = 1'b0;

        // Straight line
        step(0, 'h1123, 0, 0, 0);
        step(1, 'h0000, 0, 0, 0);
        check("add.dx_valid", dx_valid, 1);
        check("add.dx_op", dx_op, 1);
        check("add.dx_rd", dx_rd, 1);
        check("add.dx_rs", dx_rs, 2);
        check("add.dx_rt", dx_rt, 3);
        check("add.dx_pc", dx_pc, 0);

        // Jump forward, squash, target issues
        step(4, 'hC005, 0, 0, 0);
        step(5, 'h1111, 0, 0, 0);
        check("jmp.squash", dx_valid, 0);
        step(9, 'h2222, 0, 0, 0);
        step(10, 'h0000, 0, 0, 0);
        check("jmp.target_pc", dx_pc, 9);
        check("jmp.target_op", dx_op, 2);

        // Jump backward across zero
        step(0, 'hCFFF, 0, 0, 0);
        step(1, 'h0000, 0, 0, 0);
        step(2, 'h0000, 0, 0, 0);

        // Load-use
        step(20, 'h8420, 0, 0, 0);
        step(21, 'h1541, 0, 0, 0);
        step(22, 'h0000, 0, 0, 0);
        check("lduse.bubble", dx_valid, 0);
        step(22, 'h0000, 0, 0, 0);
        check("lduse.add_rs", dx_rs, 4);
        check("lduse.add_valid", dx_valid, 1);

        // Load followed by independent instruction
        step(30, 'h8420, 0, 0, 0);
        step(31, 'h1561, 0, 0, 0);
        step(32, 'h0000, 0, 0, 0);
        check("nolduse.valid", dx_valid, 1);

        // Hold from execute with a JMP waiting in IF/ID
        step(40, 'hC002, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(41, 'h0000, 0, 1, 0);
        step(41, 'h0000, 0, 0, 0);
        step(42, 'h0000, 0, 0, 0);

        // Flush overrides a JMP
        step(50, 'hC002, 0, 0, 0);
        step(51, 'h0000, 0, 0, 1);
        check("flush.dx_valid", dx_valid, 0);
        step(52, 'h0000, 0, 0, 0);

        // Randomized traffic, HALT excluded
        for (int n = 0; n < 400; n++) begin
            rop   = $urandom_range(0, 14);
            rinst = (rop << 12) | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            step($urandom_range(0, 65535), rinst, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        // Halt, then asynchronous reset between edges
        step(60, 'hF000, 0, 0, 0);
        step(61, 'h0000, 0, 0, 0);
        check("halt.op", dx_op, 15);
        check("halt.flag", halted, 1);
        for (int k = 0; k < 3; k++) step(62, 'h1123, 0, 0, 0);
        check("halt.stall", stall, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst.halted", halted, 0);
        check("arst.stall", stall, 0);
        check("arst.dx_valid", dx_valid, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 'h1123, 0, 0, 0);
        step(1, 'h0000, 0, 0, 0);
        check("after_rst.dx_op", dx_op, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage. Consumes inst_stage output (pc, inst, inst_invalid) and drives inst_stage's control inputs (stall, branch_pc, branch_to_new).
- Holds the IF/ID register and decodes the 16-bit instruction into the ID/EX register.
- Resolves unconditional jumps in decode and detects load-use hazards.
- Honours flush and hold requests from execute.

Parameters:
- PC_W, 16, width of pc and branch_pc.
- INST_W, 16, instruction width. Field layout below is fixed for 16.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-high reset.
- pc  input  PC_W  fetch pc of inst.
- inst  input  INST_W  fetched instruction.
- inst_invalid  input  1  fetch slot is a bubble.
- ex_stall  input  1  execute cannot accept; hold decode.
- ex_flush  input  1  execute resolved a taken conditional branch; squash decode.
- stall  output  1  to fetch: hold pc/inst this edge.
- branch_to_new  output  1  to fetch: redirect to branch_pc at this edge.
- branch_pc  output  PC_W  jump target.
- dx_valid  output  1  ID/EX slot holds a real instruction.
- dx_pc  output  PC_W  pc of issued instruction.
- dx_op  output  4  opcode.
- dx_rd, dx_rs, dx_rt  output  4 each  register fields.
- dx_imm  output  16  sign-extended immediate.
- halted  output  1  HALT has issued.

Behaviour:
- Fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
  - imm = sext([7:0]) for LDI.
  - imm = sext([11:0]) for JMP and BR.
- Opcodes:
  - 0x0 NOP.
  - 0x1-0x7 ALU: read rs, rt; write rd.
  - 0x8 LD: read rs; write rd.
  - 0x9 ST: read rs, rt.
  - 0xA LDI: write rd.
  - 0xB BR: read rs; passed to EX.
  - 0xC JMP.
  - 0xF HALT.
  - Other opcodes: issued as NOP with dx_valid=1.
- Reset (async, any time): IF/ID valid=0; all dx_* = 0; stall=0; branch_to_new=0; branch_pc=0; halted=0.
- IF/ID register captures {pc, inst, !inst_invalid} on each edge unless held. All logic below reads the IF/ID register (id_*). Decode latency is one cycle into ID/EX.
- Load-use hazard (ld_use): dx_valid && dx_op==LD && id_valid && id reads rs or rt matching dx_rd.
- Priority each cycle (highest first):
  1. ex_flush: IF/ID valid cleared at edge; ID/EX loaded with bubble (dx_valid=0, fields 0); branch_to_new=0; stall=0.
  2. ex_stall: IF/ID and ID/EX hold; stall=1; branch_to_new=0.
  3. halted: stall=1; ID/EX bubble; branch_to_new=0. Only rst clears halted.
  4. ld_use: stall=1; IF/ID holds; ID/EX bubble. One bubble per hazard.
  5. id_valid && id_op==JMP:
     - branch_to_new=1 (combinational); branch_pc = id_pc + imm, wrapping mod 2^PC_W.
     - ID/EX gets bubble.
     - IF/ID captures with valid forced 0, squashing the wrong-path slot. Penalty is one bubble.
  6. Normal: ID/EX loads the decoded id_* (dx_valid=id_valid). IF/ID captures fetch.
- HALT: halted is set at the edge where HALT is loaded into ID/EX. From the next cycle, stall=1 continuously.
- branch_pc is driven with the computed target whenever id_op==JMP, otherwise 0. It is only meaningful while branch_to_new=1.
- Fetch bubbles (inst_invalid=1) never cause hazards or jumps.

Decomposition:
- Package cpu_pkg: opcode enum (OP_NOP … OP_HALT); field-position localparams; typedef dx_t (packed ID/EX bundle).
- Sub-module hazard_unit: combinational ld_use plus priority resolution, producing stall, hold and bubble controls.
- decode_stage holds both registers and the field decode.

Test Plan:
- Straight line: rst pulse, then ADD r1,r2,r3 (0x1123) at pc 0 and NOP at pc 1 → at the next edge dx_valid=1, dx_op=1, dx_rd=1, dx_rs=2, dx_rt=3, dx_pc=0; stall=0 throughout.
- Jump: JMP +5 (0xC005) at pc 4 in IF/ID → branch_to_new=1, branch_pc=9 for one cycle. The following pc 5 slot is squashed (dx_valid=0 next cycle). Pc 9 issues after that. JMP -1 (0xCFFF) at pc 0 → branch_pc=0xFFFF.
- Load-use: LD r4,(r2) (0x8420) then ADD r5,r4,r1 (0x1541) → stall=1 for exactly one cycle, one dx_valid=0 bubble, ADD issues next with dx_rs=4. With rd≠rs/rt → no stall.
- Flush/hold: ex_stall=1 for 3 cycles → dx_* and stall held stable; a JMP in IF/ID does not assert branch_to_new until release. ex_flush=1 together with a JMP in IF/ID → branch_to_new=0, and the next dx_valid=0.
- Halt and reset: HALT (0xF000) → halted=1 and stall=1 indefinitely. Asserting rst mid-sequence asynchronously clears halted, stall and dx_valid without waiting for clk.
